// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory access sequencer: RV32I load/store
// funct3 codes, the sequencer state encoding and alignment/legality helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LD_LO = 3'd1,
        S_LD_HI = 3'd2,
        S_ST    = 3'd3,
        S_RESP  = 3'd4
    } state_t;

    // Halfwords only need an even address; words need a 4-byte boundary.
    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
        case (funct3)
            F3_H, F3_HU: return addr_lo[0];
            F3_W:        return (addr_lo != 2'b00);
            default:     return 1'b0;
        endcase
    endfunction

    function automatic logic is_legal(input logic we, input logic [2:0] funct3);
        if (we) begin
            return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W);
        end
        return (funct3 == F3_B) || (funct3 == F3_H) || (funct3 == F3_W) ||
               (funct3 == F3_BU) || (funct3 == F3_HU);
    endfunction

    // Index of the final byte beat of a split store (sh: 2 beats, sw: 4 beats).
    function automatic logic [1:0] last_beat(input logic [2:0] funct3);
        case (funct3)
            F3_H:    return 2'd1;
            F3_W:    return 2'd3;
            default: return 2'd0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_load_merge.sv
// Combinational load merge: shifts the {hi,lo} word pair right by the byte
// offset, then truncates and sign/zero-extends according to funct3.
// The aligned path feeds hi=0 and offset 0, so only the extension applies.
module dmem_load_merge
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_lo,
    input  logic [31:0] i_hi,
    output logic [31:0] o_data
);

    logic [63:0] w_pair;
    logic [63:0] w_shifted;

    assign w_pair    = {i_hi, i_lo};
    assign w_shifted = w_pair >> {i_off, 3'b000};

    // Select width and extension from the request funct3.
    always_comb begin
        o_data = 32'd0;
        case (i_funct3)
            F3_B:    o_data = {{24{w_shifted[7]}},  w_shifted[7:0]};
            F3_BU:   o_data = {24'd0,               w_shifted[7:0]};
            F3_H:    o_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            F3_HU:   o_data = {16'd0,               w_shifted[15:0]};
            F3_W:    o_data = w_shifted[31:0];
            default: o_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/dmem_access_seq.sv
// Access sequencer between the load/store stage and a byte-addressable data
// memory. Aligned accesses go through as one memory access; misaligned loads
// are split into two aligned word reads and merged, misaligned stores become
// a run of byte stores.
// Optional build macro DMEM_MISALIGN_TRAP_EN: misaligned requests are instead
// answered immediately with resp_err=1 and never touch memory.
module dmem_access_seq
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_err,
    output logic                  busy,
    output logic                  mem_wr_en,
    output logic [2:0]            mem_funct3,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data
);

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_funct3;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_misal;
    logic [1:0]            r_cnt;
    logic [1:0]            r_last;
    logic [DATA_WIDTH-1:0] r_lo;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;

    logic                  w_misal_in;
    logic                  w_legal_in;
    logic [ADDR_WIDTH-1:0] w_base;
    logic [7:0]            w_byte;
    logic [1:0]            w_mrg_off;
    logic [DATA_WIDTH-1:0] w_mrg_lo;
    logic [DATA_WIDTH-1:0] w_mrg_hi;
    logic [DATA_WIDTH-1:0] w_merged;

    assign w_misal_in = is_misaligned(req_funct3, req_addr[1:0]);
    assign w_legal_in = is_legal(req_we, req_funct3);
    assign w_base     = {r_addr[ADDR_WIDTH-1:2], 2'b00};
    assign w_byte     = r_wdata[{r_cnt, 3'b000} +: 8];

    assign req_ready  = (r_state == S_IDLE);
    assign busy       = (r_state != S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_err   = r_err;

    // The second read of a split load merges the saved low word with the
    // current read; every other capture is a single word with no shift.
    assign w_mrg_lo  = (r_state == S_LD_HI) ? r_lo        : mem_rd_data;
    assign w_mrg_hi  = (r_state == S_LD_HI) ? mem_rd_data : '0;
    assign w_mrg_off = (r_state == S_LD_HI) ? r_addr[1:0] : 2'b00;

    dmem_load_merge u_merge (
        .i_funct3 (r_funct3),
        .i_off    (w_mrg_off),
        .i_lo     (w_mrg_lo),
        .i_hi     (w_mrg_hi),
        .o_data   (w_merged)
    );

    // Next-state selection.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    if (!w_legal_in) begin
                        w_state_next = S_RESP;
`ifdef DMEM_MISALIGN_TRAP_EN
                    end else if (w_misal_in) begin
                        w_state_next = S_RESP;
`endif
                    end else if (req_we) begin
                        w_state_next = S_ST;
                    end else begin
                        w_state_next = S_LD_LO;
                    end
                end
            end
`ifdef DMEM_MISALIGN_TRAP_EN
            S_LD_LO: w_state_next = S_RESP;
            S_ST:    w_state_next = S_RESP;
`else
            S_LD_LO: w_state_next = r_misal ? S_LD_HI : S_RESP;
            S_LD_HI: w_state_next = S_RESP;
            S_ST:    w_state_next = (!r_misal || (r_cnt == r_last)) ? S_RESP : S_ST;
`endif
            S_RESP:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Memory-side outputs; all come from registered request fields.
    // The write enable is gated by rst_n so an abort suppresses the beat
    // that is in flight at the reset edge.
    always_comb begin
        mem_wr_en   = 1'b0;
        mem_funct3  = F3_W;
        mem_addr    = '0;
        mem_wr_data = '0;
        case (r_state)
            S_LD_LO: begin
                if (r_misal) begin
                    mem_funct3 = F3_W;
                    mem_addr   = w_base;
                end else begin
                    mem_funct3 = r_funct3;
                    mem_addr   = r_addr;
                end
            end
`ifndef DMEM_MISALIGN_TRAP_EN
            S_LD_HI: begin
                mem_funct3 = F3_W;
                mem_addr   = w_base + ADDR_WIDTH'(4);
            end
`endif
            S_ST: begin
                mem_wr_en = rst_n;
                if (r_misal) begin
                    mem_funct3  = F3_B;
                    mem_addr    = r_addr + ADDR_WIDTH'(r_cnt);
                    mem_wr_data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
                end else begin
                    mem_funct3  = r_funct3;
                    mem_addr    = r_addr;
                    mem_wr_data = r_wdata;
                end
            end
            default: ;
        endcase
    end

    // State register, request capture, beat counter and response registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_funct3 <= 3'b000;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_misal  <= 1'b0;
            r_cnt    <= 2'd0;
            r_last   <= 2'd0;
            r_lo     <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_misal  <= w_misal_in;
                        r_last   <= last_beat(req_funct3);
                        r_cnt    <= 2'd0;
                        if (w_state_next == S_RESP) begin
                            r_rdata <= '0;
                            r_err   <= 1'b1;
                        end
                    end
                end
                S_LD_LO: begin
                    r_lo <= mem_rd_data;
                    if (w_state_next == S_RESP) begin
                        r_rdata <= w_merged;
                        r_err   <= 1'b0;
                    end
                end
                S_LD_HI: begin
                    r_rdata <= w_merged;
                    r_err   <= 1'b0;
                end
                S_ST: begin
                    r_cnt <= r_cnt + 2'd1;
                    if (w_state_next == S_RESP) begin
                        r_rdata <= '0;
                        r_err   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
